// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and loads the
// IF/ID register, with stall, flush, redirect and a sticky fault for bad PCs.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    // One bit wider than the PC so the byte limit compares without overflow.
    localparam logic [32:0] PC_LIMIT = 33'(4 * IMEM_WORDS);

    function automatic logic pc_illegal(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || ({1'b0, pc} >= PC_LIMIT);
    endfunction

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc4_q, ipc4_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] count_q, count_d;

    // Next-state selection in priority order: redirect, bad PC, stall, flush, fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        ipc_d      = ipc_q;
        ipc4_d     = ipc4_q;
        instr_d    = instr_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        count_d    = count_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                valid_d = 1'b0;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end else if (pc_illegal(pc_q)) begin
                    state_d    = ST_FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = pc_q;
                    valid_d    = 1'b0;
                    instr_d    = NOP_INSTR;
                end else if (stall) begin
                    // A flush during a stall only invalidates; the PC fields stay put.
                    if (flush) begin
                        valid_d = 1'b0;
                    end else begin
                        valid_d = valid_q;
                    end
                end else if (flush) begin
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end else begin
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b1;
                    ipc_d   = pc_q;
                    ipc4_d  = pc_q + 32'd4;
                    instr_d = imem_data;
                    count_d = count_q + 32'd1;
                end
            end
            ST_FAULT: begin
                valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ST_RUN;
                    fault_d = 1'b0;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            ipc_q      <= 32'h0000_0000;
            ipc4_q     <= 32'h0000_0000;
            instr_q    <= NOP_INSTR;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0000_0000;
            count_q    <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            ipc_q      <= ipc_d;
            ipc4_q     <= ipc4_d;
            instr_q    <= instr_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_valid = valid_q;
    assign if_id_pc    = ipc_q;
    assign if_id_pc4   = ipc4_q;
    assign if_id_instr = instr_q;
    assign fetch_fault = fault_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_count = count_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch-stage requester for the word-addressed instruction memory. The memory has a combinational read, returns data only for word-aligned addresses, and decodes byte-address bits [11:2], giving 1024 words.
This block owns the PC, drives the memory address, and captures the returned word into the IF/ID pipeline register. It supports stall, flush, branch/jump redirect and a sticky fetch-fault state for misaligned or out-of-range PCs. It sits between the instruction memory and the decode stage of the pipelined CPU.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
IMEM_WORDS, 1024, instruction memory depth in words; the legal byte range is 0 .. 4*IMEM_WORDS-1.
NOP_INSTR, 32'h0000_0000, instruction placed in if_id_instr whenever a bubble is inserted.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
imem_addr  output  32  byte address to instruction memory; equals the pc register combinationally.
imem_data  input  32  instruction word returned combinationally by memory in the same cycle.
stall  input  1  hold PC and IF/ID contents.
flush  input  1  kill the IF/ID contents (insert bubble).
redirect_valid  input  1  load a new PC (branch/jump taken).
redirect_pc  input  32  target PC for redirect.
if_id_valid  output  1  IF/ID register holds a real instruction.
if_id_pc  output  32  PC of the instruction in IF/ID.
if_id_pc4  output  32  if_id_pc + 4.
if_id_instr  output  32  fetched instruction.
fetch_fault  output  1  sticky fault flag.
fault_pc  output  32  PC that caused the fault.
fetch_count  output  32  number of instructions delivered with valid=1.

Behaviour:
- FSM states: BOOT, RUN, FAULT.
- Reset (rst=1 at an edge):
  - State goes to BOOT; pc=RESET_PC.
  - if_id_valid=0, if_id_pc=0, if_id_pc4=0, if_id_instr=NOP_INSTR.
  - fetch_fault=0, fault_pc=0, fetch_count=0.
  - Reset overrides every other input, including in mid-stall and in FAULT.
- BOOT: one cycle with no fetch; if_id_valid=0; pc holds; next state is RUN. Redirect and stall are ignored in BOOT.
- Illegal PC (evaluated combinationally in RUN): pc[1:0]!=0, or pc >= 4*IMEM_WORDS.
- RUN, priority order per edge:
  1. redirect_valid=1:
     - pc <= redirect_pc.
     - IF/ID gets a bubble: valid=0, instr=NOP_INSTR; pc fields are don't-care but held.
     - Beats stall, flush and a current illegal PC.
  2. Current pc illegal (no redirect):
     - Next state is FAULT; fetch_fault <= 1; fault_pc <= pc.
     - IF/ID gets a bubble; pc holds. This applies even if stall=1.
  3. stall=1:
     - pc and all if_id_* outputs hold; fetch_count holds.
     - If flush=1 as well, only if_id_valid is cleared.
  4. flush=1 (no stall): pc <= pc+4; IF/ID gets a bubble; fetch_count holds.
  5. Normal fetch:
     - if_id_instr <= imem_data, if_id_pc <= pc, if_id_pc4 <= pc+4, if_id_valid <= 1.
     - pc <= pc+4; fetch_count <= fetch_count+1.
- Latency: the word at address A appears on if_id_* one edge after imem_addr=A. Throughput is one instruction per cycle with no stalls.
- FAULT:
  - pc holds; if_id_valid=0; stall and flush are ignored.
  - Only redirect_valid or rst exits.
  - On redirect: pc <= redirect_pc, next state is RUN, fetch_fault <= 0. fault_pc keeps its last value.
  - If redirect_pc is itself illegal, the unit re-faults on the next edge.
- Arithmetic: pc+4 and fetch_count wrap modulo 2^32 with no saturation. In practice pc reaches the range fault before it can wrap.
- imem_addr is never gated; memory-side high-Z on misaligned data is never captured, because a misaligned pc always takes the fault path.

Test Plan:
- Reset, then free-run with memory preloaded words 0x11,0x22,0x33 at 0,4,8:
  - One BOOT bubble after rst falls.
  - Then if_id_instr = 0x11,0x22,0x33 with if_id_pc = 0,4,8 on consecutive cycles.
  - fetch_count = 3.
- stall=1 for 2 cycles at pc=8:
  - imem_addr stays 8; if_id_pc stays 4; fetch_count is unchanged.
  - After release, 0x33 is delivered.
- redirect_valid=1, redirect_pc=0x40, together with stall=1:
  - Next cycle: if_id_valid=0, imem_addr=0x40.
  - The cycle after: if_id_pc=0x40.
- redirect_pc=0x42:
  - The next edge sets fetch_fault=1, fault_pc=0x42, if_id_valid=0.
  - Stall and flush then have no effect.
  - redirect_pc=0x10 clears the fault and fetching resumes at 0x10.
- Run from pc=0xFFC with IMEM_WORDS=1024: word at 0xFFC is delivered, then fault with fault_pc=0x1000.
- Assert rst while in FAULT with stall=1: all outputs return to their reset values within one edge.
